// File: rtl/ula_serial_ctrl.sv
// Nibble-serial sequencer driving one ula_74181 slice per cycle, LSB first, to build a 4*NIBBLES-bit result.
// Optional macro ULA_SERIAL_EQ_EN adds result_eq, the AND of alu_a_eq_b over all slices.
module ula_serial_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int KW = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   op_s,
  input  logic         op_m,
  input  logic         op_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         result_cout,
  output logic         result_zero,
`ifdef ULA_SERIAL_EQ_EN
  output logic         result_eq,
`endif
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_cin,
  input  logic [3:0]   alu_f,
  input  logic         alu_c_out,
  input  logic         alu_a_eq_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          zero_q, zero_d;
  logic          slice_carry;
  logic          last_slice;

  // The ALU reports c_out in borrow polarity for these selects; flip it back to a true carry.
  function automatic logic cout_inverted(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0010, 4'b0011,
      4'b0110, 4'b0111, 4'b1011: cout_inverted = 1'b1;
      default:                   cout_inverted = 1'b0;
    endcase
  endfunction

  function automatic logic true_carry(input logic c_out, input logic [3:0] s, input logic m);
    true_carry = m ? 1'b0 : (c_out ^ cout_inverted(s));
  endfunction

  assign slice_carry = true_carry(alu_c_out, s_q, m_q);
  assign last_slice  = (k_q == KW'(NIBBLES - 1));

`ifdef ULA_SERIAL_EQ_EN
  logic eq_acc_q, eq_acc_d;
  logic eq_q, eq_d;

  always_comb begin
    eq_acc_d = eq_acc_q;
    eq_d     = eq_q;
    case (state_q)
      IDLE: if (in_valid) eq_acc_d = 1'b1;
      RUN: begin
        eq_acc_d = eq_acc_q & alu_a_eq_b;
        if (last_slice) eq_d = eq_acc_q & alu_a_eq_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_acc_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      eq_acc_q <= eq_acc_d;
      eq_q     <= eq_d;
    end
  end

  assign result_eq = eq_q;
`else
  logic unused_eq;
  assign unused_eq = alu_a_eq_b;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    k_d      = k_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = op_a;
          b_d      = op_b;
          s_d      = op_s;
          m_d      = op_m;
          carry_d  = op_cin;
          k_d      = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == i[KW-1:0]) result_d[4*i +: 4] = alu_f;
        end
        carry_d = slice_carry;
        k_d     = k_q + 1'b1;
        if (last_slice) begin
          cout_d  = slice_carry;
          zero_d  = (result_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  // Slice select for the operands currently presented to the ALU.
  always_comb begin
    alu_a = 4'h0;
    alu_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == i[KW-1:0]) begin
        alu_a = a_q[4*i +: 4];
        alu_b = b_q[4*i +: 4];
      end
    end
  end

  assign alu_s       = s_q;
  assign alu_m       = m_q;
  assign alu_cin     = carry_q & ~m_q;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign result_cout = cout_q;
  assign result_zero = zero_q;

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Self-checking bench for ula_serial_ctrl with a behavioural 74181 slice and a wide-word reference model.
module tb_ula_serial_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_s;
  logic         op_m, op_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         result_cout, result_zero;
`ifdef ULA_SERIAL_EQ_EN
  logic         result_eq;
`endif
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cin, alu_c_out, alu_a_eq_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ula_serial_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .result_zero(result_zero),
`ifdef ULA_SERIAL_EQ_EN
    .result_eq(result_eq),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b)
  );

  // 74181 slice, active-high data: F = X + Y + cin (arith) or ~(X ^ Y) (logic).
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    sy = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    ssum = {1'b0, sx} + {1'b0, sy} + {4'b0000, alu_cin};
    if (alu_m) begin
      alu_f     = ~(sx ^ sy);
      alu_c_out = 1'b1;
    end else begin
      alu_f = ssum[3:0];
      case (alu_s)
        4'b0000, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1011: alu_c_out = ~ssum[4];
        default: alu_c_out = ssum[4];
      endcase
    end
    alu_a_eq_b = (alu_f == 4'hF);
  end

  // Whole-word reference: {true carry out, W-bit result}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] s, input logic m, input logic cin);
    logic [W-1:0] x, y;
    x = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    if (m) return {1'b0, ~(x ^ y)};
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  endfunction

  // Issue one request from a negedge in IDLE; return at the negedge where out_valid is seen (or timeout).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                       input logic m, input logic cin,
                       output int lat, output logic cin_seen, output int acc_cyc);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
    in_valid = 1'b1;
    cin_seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc = cyc;
    op_a = W'($urandom); op_b = W'($urandom); op_s = 4'($urandom); op_m = 1'($urandom); op_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      cin_seen = cin_seen | alu_cin;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%h want=0", result); end
    n_cmp++; if ({result_cout, result_zero} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b want=00", {result_cout, result_zero}); end
    n_cmp++; if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'h0) begin n_err++; $display("FAIL reset_alu got=%h want=0", {alu_a, alu_b, alu_s, alu_m, alu_cin}); end
  endtask

  task automatic test_add();
    int lat, acc; logic cs;
    do_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, lat, cs, acc);
    n_cmp++; if (lat !== N) begin n_err++; $display("FAIL add_latency got=%0d want=%0d", lat, N); end
    n_cmp++; if (result !== 16'h2201) begin n_err++; $display("FAIL add_result got=%h want=2201", result); end
    n_cmp++; if ({result_cout, result_zero} !== 2'b00) begin n_err++; $display("FAIL add_flags got=%b want=00", {result_cout, result_zero}); end
    consume();
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, cs, acc);
    n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL ripple_result got=%h want=0000", result); end
    n_cmp++; if ({result_cout, result_zero} !== 2'b11) begin n_err++; $display("FAIL ripple_flags got=%b want=11", {result_cout, result_zero}); end
    consume();
  endtask

  task automatic test_sub();
    int lat, acc; logic cs;
    do_op(16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1, lat, cs, acc);
    n_cmp++; if ({result_cout, result} !== {1'b0, 16'hFFFE}) begin n_err++; $display("FAIL sub_neg got=%b_%h want=0_fffe", result_cout, result); end
    consume();
    do_op(16'h0007, 16'h0005, 4'b0110, 1'b0, 1'b1, lat, cs, acc);
    n_cmp++; if ({result_cout, result} !== {1'b1, 16'h0002}) begin n_err++; $display("FAIL sub_pos got=%b_%h want=1_0002", result_cout, result); end
    consume();
  endtask

  task automatic test_logic();
    int lat, acc; logic cs;
    do_op(16'hAAAA, 16'h5555, 4'b0110, 1'b1, 1'b1, lat, cs, acc);
    n_cmp++; if ({result_cout, result} !== {1'b0, 16'hFFFF}) begin n_err++; $display("FAIL logic_xor got=%b_%h want=0_ffff", result_cout, result); end
    n_cmp++; if (cs !== 1'b0) begin n_err++; $display("FAIL logic_alu_cin got=%b want=0", cs); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, acc; logic cs; logic bad;
    logic [W:0] exp2;
    out_ready = 1'b0;
    do_op(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b0, lat, cs, acc);
    op_a = 16'h0F0F; op_b = 16'h0101; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b1;
    in_valid = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (result !== 16'h5432 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL bp_hold got_result=%h ov=%b ir=%b want=5432/1/0", result, out_valid, in_ready); end
    in_valid = 1'b0;
    consume();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL bp_release got=%b want=10", {in_ready, out_valid}); end
    exp2 = ref_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1);
    do_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, lat, cs, acc);
    n_cmp++; if (lat !== N) begin n_err++; $display("FAIL bp_next_latency got=%0d want=%0d", lat, N); end
    n_cmp++; if ({result_cout, result} !== exp2) begin n_err++; $display("FAIL bp_next_result got=%h want=%h", {result_cout, result}, exp2); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, acc1, acc2; logic cs;
    do_op(16'h00FF, 16'h0F00, 4'b1001, 1'b0, 1'b0, lat, cs, acc1);
    consume();
    do_op(16'h1000, 16'h2000, 4'b1001, 1'b0, 1'b0, lat, cs, acc2);
    n_cmp++; if (acc2 - acc1 !== N + 2) begin n_err++; $display("FAIL b2b_spacing got=%0d want=%0d", acc2 - acc1, N + 2); end
    n_cmp++; if (result !== 16'h3000) begin n_err++; $display("FAIL b2b_result got=%h want=3000", result); end
    consume();
  endtask

  task automatic test_random();
    int lat, acc; logic cs;
    logic [W-1:0] a, b; logic [3:0] s; logic m, c;
    logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); s = 4'($urandom_range(0, 15));
      m = 1'($urandom); c = 1'($urandom);
      if (i % 6 == 0) b = a;
      exp = ref_op(a, b, s, m, c);
      out_ready = 1'($urandom);
      do_op(a, b, s, m, c, lat, cs, acc);
      n_cmp++; if (lat !== N) begin n_err++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, N); end
      n_cmp++;
      if ({result_cout, result, result_zero} !== {exp, exp[W-1:0] == '0}) begin
        n_err++;
        $display("FAIL rand_result[%0d] a=%h b=%h s=%b m=%b cin=%b got=%b_%h_z%b want=%b_%h_z%b",
                 i, a, b, s, m, c, result_cout, result, result_zero, exp[W], exp[W-1:0], exp[W-1:0] == '0);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
      consume();
    end
  endtask

  task automatic test_reset_midrun();
    logic stale;
    op_a = 16'h7777; op_b = 16'h1111; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL midrun_hs got=%b want=10", {in_ready, out_valid}); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL midrun_result got=%h want=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL midrun_stale got=1 want=0"); end
  endtask

`ifdef ULA_SERIAL_EQ_EN
  task automatic test_eq();
    int lat, acc; logic cs;
    do_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b0, lat, cs, acc);
    n_cmp++; if (result_eq !== 1'b1) begin n_err++; $display("FAIL eq_equal got=%b want=1", result_eq); end
    consume();
    do_op(16'h3C3C, 16'h3C2C, 4'b0110, 1'b0, 1'b0, lat, cs, acc);
    n_cmp++; if (result_eq !== 1'b0) begin n_err++; $display("FAIL eq_differ got=%b want=0", result_eq); end
    consume();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_add();
    test_sub();
    test_logic();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef ULA_SERIAL_EQ_EN
    test_eq();
`endif
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ula_serial_ctrl.md
Name: ula_serial_ctrl

Overview:
Nibble-serial sequencer that sits directly upstream of ula_74181. It drives ula_74181 one 4-bit slice per cycle, least-significant first, to perform a 4*NIBBLES-bit operation. It chains the carry between slices and assembles the wide result. Operands are accepted and results are returned through valid/ready handshakes.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request (high only in IDLE)
op_a  input  W  operand A
op_b  input  W  operand B
op_s  input  4  function select, passed to ula_74181 s
op_m  input  1  mode (1 = logic, 0 = arithmetic)
op_cin  input  1  true carry-in to slice 0 (active high)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  assembled F
result_cout  output  1  true carry out of top slice; 0 in logic mode
result_zero  output  1  result == 0
alu_a  output  4  to ula_74181 a
alu_b  output  4  to ula_74181 b
alu_s  output  4  to ula_74181 s
alu_m  output  1  to ula_74181 m
alu_cin  output  1  to ula_74181 c_in
alu_f  input  4  from ula_74181 f
alu_c_out  input  1  from ula_74181 c_out
alu_a_eq_b  input  1  from ula_74181 a_eq_b

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; in_ready = 1; out_valid = 0; result = 0; result_cout = 0; result_zero = 0; slice counter = 0; all alu_* outputs = 0. Reset asserted mid-RUN or mid-DONE discards the operation. No output appears afterwards.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: in_ready = 1.
  - On in_valid & in_ready at an edge, latch op_a, op_b, op_s, op_m and op_cin.
  - Clear the result register, set k = 0 and carry = op_cin, then go to RUN.
- RUN: in_ready = 0.
  - Combinationally drive alu_a = A[4k+3:4k] and alu_b = B[4k+3:4k].
  - Drive alu_s and alu_m from the latched values, and alu_cin = carry (0 when m = 1).
  - At each edge, write alu_f into result[4k+3:4k].
  - At the same edge, load carry with the true carry of the slice:
    - alu_c_out inverted when S is in {0000, 0010, 0011, 0110, 0111, 1011};
    - alu_c_out unchanged for all other S;
    - 0 in logic mode.
  - Increment k. After the edge with k = NIBBLES-1, go to DONE.
- DONE: out_valid = 1.
  - result, result_cout and result_zero are stable and held until out_ready is high at an edge; then go to IDLE.
  - result_cout = the true carry of the final slice.
  - result_zero is registered at the DONE transition.
- Latency: accept edge to out_valid = NIBBLES cycles. With out_ready tied high, the minimum request spacing is NIBBLES+2 cycles.
- Handshake rules:
  - in_valid is ignored outside IDLE; no request is accepted in the same cycle a result is consumed.
  - out_valid never drops without out_ready.
  - Inputs may change after acceptance without affecting the operation in flight.
- Arithmetic is modulo 2^W. Overflow beyond W bits is visible only in result_cout.
- alu_* outputs retain their last-driven values in IDLE and DONE; they are don't-care there.

Optional Feature:
ULA_SERIAL_EQ_EN
- Defined: adds output port result_eq (1 bit). It is the AND of alu_a_eq_b across all slices, accumulated in RUN and registered at DONE; it is 0 at reset. With S = 0110, M = 0 and op_cin = 0, result_eq = 1 iff op_a == op_b.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. NIBBLES=4, M=0, S=1001, A=0x1234, B=0x0FCD, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; result=0x2201, cout=0, zero=0.
2. M=0, S=1001, A=0xFFFF, B=0x0001, cin=0 -> result=0x0000, cout=1, zero=1; carry ripples through all four slices.
3. M=0, S=0110, A=0x0005, B=0x0007, cin=1 (A minus B) -> result=0xFFFE, cout=0. Then A=0x0007, B=0x0005, cin=1 -> result=0x0002, cout=1.
4. M=1, S=0110, A=0xAAAA, B=0x5555, cin=1 -> result=0xFFFF, cout=0; alu_cin=0 in every RUN cycle.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> result stays constant, in_ready=0, no new accept. After out_ready=1: IDLE, next request accepted, latency again 4.
6. Assert rst_n low during RUN slice 2 -> immediately out_valid=0, in_ready=1, result=0. No stale out_valid after release. With ULA_SERIAL_EQ_EN, S=0110, cin=0, A=B=0x3C3C -> result_eq=1.
